// File: rtl/snake_game_pkg.sv
// Shared types and constants for the snake game-flow sequencer.
package snake_game_pkg;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned SCORE_W = 8;
    localparam int unsigned BOX_W   = 11;

    typedef enum logic [2:0] {
        ST_ATTRACT = 3'd0,
        ST_SPAWN   = 3'd1,
        ST_PLAY    = 3'd2,
        ST_PAUSE   = 3'd3,
        ST_OVER    = 3'd4
    } state_t;

    localparam logic [7:0] KEY_START = 8'h28;
    localparam logic [7:0] KEY_PAUSE = 8'h13;

    localparam logic [COORD_W-1:0] FALLBACK_X = 10'd320;
    localparam logic [COORD_W-1:0] FALLBACK_Y = 10'd240;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (v == '1) ? v : v + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/box_overlap.sv
// Combinational 2-D box overlap test on signed, closed intervals.
module box_overlap
    import snake_game_pkg::*;
(
    input  logic signed [BOX_W-1:0] a_x_lo,
    input  logic signed [BOX_W-1:0] a_x_hi,
    input  logic signed [BOX_W-1:0] a_y_lo,
    input  logic signed [BOX_W-1:0] a_y_hi,
    input  logic signed [BOX_W-1:0] b_x_lo,
    input  logic signed [BOX_W-1:0] b_x_hi,
    input  logic signed [BOX_W-1:0] b_y_lo,
    input  logic signed [BOX_W-1:0] b_y_hi,
    output logic                    overlap_c
);

    assign overlap_c = (a_x_lo <= b_x_hi) && (b_x_lo <= a_x_hi) &&
                       (a_y_lo <= b_y_hi) && (b_y_lo <= a_y_hi);

endmodule

// File: rtl/snake_game_ctrl.sv
// Game-flow sequencer: frame tick, key events, food spawn, collisions and scoring.
module snake_game_ctrl
    import snake_game_pkg::*;
#(
    parameter int unsigned FIELD_X_MIN = 16,
    parameter int unsigned FIELD_X_MAX = 623,
    parameter int unsigned FIELD_Y_MIN = 16,
    parameter int unsigned FIELD_Y_MAX = 463,
    parameter int unsigned FOOD_SIZE   = 8,
    parameter int unsigned MAX_TRIES   = 16,
    parameter int unsigned WIN_SCORE   = 10,
    parameter int unsigned OVER_FRAMES = 60
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_clk,
    input  logic [15:0]        keycode,
    input  logic [19:0]        randCord,
    input  logic [COORD_W-1:0] snake1X,
    input  logic [COORD_W-1:0] snake1Y,
    input  logic [COORD_W-1:0] snake2X,
    input  logic [COORD_W-1:0] snake2Y,
    input  logic [COORD_W-1:0] snake_size,
    input  logic               OB1Flag,
    input  logic               OB2Flag,
    output logic               run_en,
    output logic [COORD_W-1:0] foodX,
    output logic [COORD_W-1:0] foodY,
    output logic               food_valid,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [1:0]         winner,
    output logic [2:0]         game_state
);

    localparam int unsigned TRIES_W = $clog2(MAX_TRIES + 1);
    localparam int unsigned OVER_W  = $clog2(OVER_FRAMES + 1);

    localparam logic [COORD_W-1:0] X_LO = COORD_W'(FIELD_X_MIN);
    localparam logic [COORD_W-1:0] X_HI = COORD_W'(FIELD_X_MAX - FOOD_SIZE + 1);
    localparam logic [COORD_W-1:0] Y_LO = COORD_W'(FIELD_Y_MIN);
    localparam logic [COORD_W-1:0] Y_HI = COORD_W'(FIELD_Y_MAX - FOOD_SIZE + 1);
    localparam logic signed [BOX_W-1:0] FOOD_EXT = BOX_W'(FOOD_SIZE - 1);

    state_t               state, state_d;
    logic [2:0]           fsync;
    logic                 frame_tick;
    logic                 start_prev, pause_prev;
    logic [TRIES_W-1:0]   tries, tries_d;
    logic [OVER_W-1:0]    over_cnt, over_cnt_d;
    logic                 run_en_d, food_valid_d;
    logic [COORD_W-1:0]   food_x_d, food_y_d;
    logic [SCORE_W-1:0]   score1_d, score2_d;
    logic [1:0]           winner_d;

    // Key events: either HID byte may carry the key; only the press edge counts.
    logic start_now, pause_now, start_ev, pause_ev;
    assign start_now = (keycode[15:8] == KEY_START) || (keycode[7:0] == KEY_START);
    assign pause_now = (keycode[15:8] == KEY_PAUSE) || (keycode[7:0] == KEY_PAUSE);
    assign start_ev  = start_now && !start_prev;
    assign pause_ev  = pause_now && !pause_prev;

    // During SPAWN the food instances judge the random candidate instead of the live food.
    logic [COORD_W-1:0]       cand_x, cand_y, box_x, box_y;
    logic signed [BOX_W-1:0]  f_x_lo, f_x_hi, f_y_lo, f_y_hi;
    logic signed [BOX_W-1:0]  h1_x_lo, h1_x_hi, h1_y_lo, h1_y_hi;
    logic signed [BOX_W-1:0]  h2_x_lo, h2_x_hi, h2_y_lo, h2_y_hi;
    logic                     ov_f1, ov_f2, ov_h;

    assign cand_x = randCord[19:10];
    assign cand_y = randCord[9:0];
    assign box_x  = (state == ST_SPAWN) ? cand_x : foodX;
    assign box_y  = (state == ST_SPAWN) ? cand_y : foodY;

    assign f_x_lo  = $signed({1'b0, box_x});
    assign f_x_hi  = f_x_lo + FOOD_EXT;
    assign f_y_lo  = $signed({1'b0, box_y});
    assign f_y_hi  = f_y_lo + FOOD_EXT;
    assign h1_x_lo = $signed({1'b0, snake1X}) - $signed({1'b0, snake_size});
    assign h1_x_hi = $signed({1'b0, snake1X}) + $signed({1'b0, snake_size});
    assign h1_y_lo = $signed({1'b0, snake1Y}) - $signed({1'b0, snake_size});
    assign h1_y_hi = $signed({1'b0, snake1Y}) + $signed({1'b0, snake_size});
    assign h2_x_lo = $signed({1'b0, snake2X}) - $signed({1'b0, snake_size});
    assign h2_x_hi = $signed({1'b0, snake2X}) + $signed({1'b0, snake_size});
    assign h2_y_lo = $signed({1'b0, snake2Y}) - $signed({1'b0, snake_size});
    assign h2_y_hi = $signed({1'b0, snake2Y}) + $signed({1'b0, snake_size});

    box_overlap u_ov_f1 (
        .a_x_lo(f_x_lo),  .a_x_hi(f_x_hi),  .a_y_lo(f_y_lo),  .a_y_hi(f_y_hi),
        .b_x_lo(h1_x_lo), .b_x_hi(h1_x_hi), .b_y_lo(h1_y_lo), .b_y_hi(h1_y_hi),
        .overlap_c(ov_f1)
    );
    box_overlap u_ov_f2 (
        .a_x_lo(f_x_lo),  .a_x_hi(f_x_hi),  .a_y_lo(f_y_lo),  .a_y_hi(f_y_hi),
        .b_x_lo(h2_x_lo), .b_x_hi(h2_x_hi), .b_y_lo(h2_y_lo), .b_y_hi(h2_y_hi),
        .overlap_c(ov_f2)
    );
    box_overlap u_ov_h (
        .a_x_lo(h1_x_lo), .a_x_hi(h1_x_hi), .a_y_lo(h1_y_lo), .a_y_hi(h1_y_hi),
        .b_x_lo(h2_x_lo), .b_x_hi(h2_x_hi), .b_y_lo(h2_y_lo), .b_y_hi(h2_y_hi),
        .overlap_c(ov_h)
    );

    logic cand_ok, dead1, dead2, eat1, eat2, win1, win2;
    assign cand_ok = (cand_x >= X_LO) && (cand_x <= X_HI) &&
                     (cand_y >= Y_LO) && (cand_y <= Y_HI) && !ov_f1 && !ov_f2;
    assign dead1   = OB1Flag || ov_h;
    assign dead2   = OB2Flag || ov_h;
    assign eat1    = ov_f1 && food_valid;
    assign eat2    = ov_f2 && food_valid;
    assign win1    = eat1 && (sat_inc(score1) == SCORE_W'(WIN_SCORE));
    assign win2    = eat2 && (sat_inc(score2) == SCORE_W'(WIN_SCORE));

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state;
        tries_d      = tries;
        over_cnt_d   = over_cnt;
        food_x_d     = foodX;
        food_y_d     = foodY;
        food_valid_d = food_valid;
        score1_d     = score1;
        score2_d     = score2;
        winner_d     = winner;
        case (state)
            ST_ATTRACT: begin
                if (start_ev) begin
                    score1_d = '0;
                    score2_d = '0;
                    winner_d = 2'b00;
                    tries_d  = '0;
                    state_d  = ST_SPAWN;
                end
            end
            ST_SPAWN: begin
                if (tries >= TRIES_W'(MAX_TRIES)) begin
                    food_x_d     = FALLBACK_X;
                    food_y_d     = FALLBACK_Y;
                    food_valid_d = 1'b1;
                    state_d      = ST_PLAY;
                end else if (cand_ok) begin
                    food_x_d     = cand_x;
                    food_y_d     = cand_y;
                    food_valid_d = 1'b1;
                    state_d      = ST_PLAY;
                end else begin
                    tries_d = tries + TRIES_W'(1);
                end
            end
            ST_PLAY: begin
                if (frame_tick) begin
                    if (dead1 || dead2) begin
                        winner_d   = {dead1, dead2};
                        over_cnt_d = '0;
                        state_d    = ST_OVER;
                    end else if (eat1 || eat2) begin
                        score1_d     = eat1 ? sat_inc(score1) : score1;
                        score2_d     = eat2 ? sat_inc(score2) : score2;
                        food_valid_d = 1'b0;
                        tries_d      = '0;
                        state_d      = ST_SPAWN;
                        if (win1 || win2) begin
                            winner_d   = {win2, win1};
                            over_cnt_d = '0;
                            state_d    = ST_OVER;
                        end
                    end
                end
                if (pause_ev && (state_d == ST_PLAY)) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (pause_ev) begin
                    state_d = ST_PLAY;
                end
            end
            ST_OVER: begin
                if (frame_tick && (over_cnt != OVER_W'(OVER_FRAMES))) begin
                    over_cnt_d = over_cnt + OVER_W'(1);
                end
                if (start_ev && (over_cnt == OVER_W'(OVER_FRAMES))) begin
                    score1_d     = '0;
                    score2_d     = '0;
                    winner_d     = 2'b00;
                    food_valid_d = 1'b0;
                    tries_d      = '0;
                    state_d      = ST_SPAWN;
                end
            end
            default: state_d = ST_ATTRACT;
        endcase
        run_en_d = (state_d == ST_PLAY);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= ST_ATTRACT;
            fsync      <= '0;
            frame_tick <= 1'b0;
            start_prev <= 1'b0;
            pause_prev <= 1'b0;
            tries      <= '0;
            over_cnt   <= '0;
            run_en     <= 1'b0;
            foodX      <= '0;
            foodY      <= '0;
            food_valid <= 1'b0;
            score1     <= '0;
            score2     <= '0;
            winner     <= 2'b00;
        end else begin
            state      <= state_d;
            fsync      <= {fsync[1:0], frame_clk};
            frame_tick <= fsync[1] && !fsync[2];
            start_prev <= start_now;
            pause_prev <= pause_now;
            tries      <= tries_d;
            over_cnt   <= over_cnt_d;
            run_en     <= run_en_d;
            foodX      <= food_x_d;
            foodY      <= food_y_d;
            food_valid <= food_valid_d;
            score1     <= score1_d;
            score2     <= score2_d;
            winner     <= winner_d;
        end
    end

    assign game_state = state;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl with hand-computed expectations.
module tb_snake_game_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        frame_clk;
    logic [15:0] keycode;
    logic [19:0] randCord;
    logic [9:0]  snake1X, snake1Y, snake2X, snake2Y, snake_size;
    logic        OB1Flag, OB2Flag;
    logic        run_en;
    logic [9:0]  foodX, foodY;
    logic        food_valid;
    logic [7:0]  score1, score2;
    logic [1:0]  winner;
    logic [2:0]  game_state;

    int errors = 0;
    int checks = 0;

    snake_game_ctrl dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .keycode(keycode),
        .randCord(randCord), .snake1X(snake1X), .snake1Y(snake1Y),
        .snake2X(snake2X), .snake2Y(snake2Y), .snake_size(snake_size),
        .OB1Flag(OB1Flag), .OB2Flag(OB2Flag), .run_en(run_en),
        .foodX(foodX), .foodY(foodY), .food_valid(food_valid),
        .score1(score1), .score2(score2), .winner(winner), .game_state(game_state)
    );

    always #10 Clk = ~Clk;

    task automatic tick_clk(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Low for 3 clocks, then high; returns just after the FSM acted on the tick.
    task automatic frame_pulse();
        tick_clk(3);
        frame_clk = 1'b1;
        tick_clk(4);
        frame_clk = 1'b0;
    endtask

    task automatic test_reset();
        #2 Reset_n = 1'b0;
        #3;
        checks++; if (game_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", game_state); end
        checks++; if (run_en !== 1'b0) begin errors++; $display("FAIL reset_run_en: got %0b want 0", run_en); end
        checks++; if ({score1, score2, winner, food_valid, foodX, foodY} !== '0) begin
            errors++; $display("FAIL reset_outputs: s1=%0d s2=%0d w=%0b fv=%0b fx=%0d fy=%0d want all 0",
                               score1, score2, winner, food_valid, foodX, foodY); end
        tick_clk(2);
        Reset_n = 1'b1;
        tick_clk(2);
        checks++; if (game_state !== 3'd0) begin errors++; $display("FAIL reset_idle: got %0d want 0", game_state); end
    endtask

    task automatic test_start();
        keycode = 16'h0028;
        tick_clk(1);
        checks++; if (game_state !== 3'd1 || run_en !== 1'b0) begin
            errors++; $display("FAIL start_spawn: state=%0d run_en=%0b want 1/0", game_state, run_en); end
        tick_clk(1);
        checks++; if (game_state !== 3'd2 || run_en !== 1'b1) begin
            errors++; $display("FAIL start_play: state=%0d run_en=%0b want 2/1", game_state, run_en); end
        checks++; if (foodX !== 10'd100 || foodY !== 10'd100 || food_valid !== 1'b1) begin
            errors++; $display("FAIL start_food: fx=%0d fy=%0d fv=%0b want 100/100/1", foodX, foodY, food_valid); end
        tick_clk(98);
        checks++; if (game_state !== 3'd2) begin errors++; $display("FAIL start_held: got %0d want 2", game_state); end
        keycode = 16'h0000;
        tick_clk(1);
    endtask

    task automatic test_eat_single();
        snake1X = 10'd104; snake1Y = 10'd104;
        randCord = {10'd200, 10'd200};
        frame_pulse();
        checks++; if (score1 !== 8'd1 || score2 !== 8'd0) begin
            errors++; $display("FAIL eat1_score: s1=%0d s2=%0d want 1/0", score1, score2); end
        checks++; if (game_state !== 3'd1 || food_valid !== 1'b0) begin
            errors++; $display("FAIL eat1_spawn: state=%0d fv=%0b want 1/0", game_state, food_valid); end
        tick_clk(1);
        checks++; if (game_state !== 3'd2 || foodX !== 10'd200 || foodY !== 10'd200) begin
            errors++; $display("FAIL eat1_respawn: state=%0d fx=%0d fy=%0d want 2/200/200", game_state, foodX, foodY); end
    endtask

    task automatic test_eat_both();
        snake1X = 10'd196; snake1Y = 10'd204;
        snake2X = 10'd208; snake2Y = 10'd196;
        randCord = {10'd700, 10'd10};
        frame_pulse();
        checks++; if (score1 !== 8'd2 || score2 !== 8'd1) begin
            errors++; $display("FAIL eat_both_score: s1=%0d s2=%0d want 2/1", score1, score2); end
        checks++; if (game_state !== 3'd1) begin errors++; $display("FAIL eat_both_spawn: got %0d want 1", game_state); end
    endtask

    task automatic test_spawn_fallback();
        tick_clk(16);
        checks++; if (game_state !== 3'd1) begin errors++; $display("FAIL fallback_retry: got %0d want 1", game_state); end
        tick_clk(1);
        checks++; if (game_state !== 3'd2 || foodX !== 10'd320 || foodY !== 10'd240 || food_valid !== 1'b1) begin
            errors++; $display("FAIL fallback_food: state=%0d fx=%0d fy=%0d fv=%0b want 2/320/240/1",
                               game_state, foodX, foodY, food_valid); end
    endtask

    task automatic test_pause();
        randCord = {10'd500, 10'd400};
        keycode = 16'h0013;
        tick_clk(1);
        checks++; if (game_state !== 3'd3 || run_en !== 1'b0) begin
            errors++; $display("FAIL pause_enter: state=%0d run_en=%0b want 3/0", game_state, run_en); end
        keycode = 16'h0000;
        snake1X = 10'd324; snake1Y = 10'd244;
        frame_pulse();
        checks++; if (score1 !== 8'd2 || game_state !== 3'd3) begin
            errors++; $display("FAIL pause_tick_ignored: s1=%0d state=%0d want 2/3", score1, game_state); end
        keycode = 16'h1300;
        tick_clk(1);
        checks++; if (game_state !== 3'd2 || run_en !== 1'b1) begin
            errors++; $display("FAIL pause_resume: state=%0d run_en=%0b want 2/1", game_state, run_en); end
        keycode = 16'h0000;
        snake1X = 10'd50; snake1Y = 10'd50;
        tick_clk(1);
    endtask

    task automatic test_win();
        logic [9:0] fx, fy;
        fx = 10'd320; fy = 10'd240;
        for (int i = 0; i < 9; i++) begin
            snake2X = fx + 10'd4; snake2Y = fy + 10'd4;
            frame_pulse();
            snake2X = 10'd50; snake2Y = 10'd400;
            if (i < 8) begin
                checks++; if (score2 !== 8'(i + 2) || game_state !== 3'd1) begin
                    errors++; $display("FAIL win_step%0d: s2=%0d state=%0d want %0d/1", i, score2, game_state, i + 2); end
                tick_clk(1);
                fx = 10'd500; fy = 10'd400;
            end
        end
        checks++; if (score2 !== 8'd10 || score1 !== 8'd2) begin
            errors++; $display("FAIL win_score: s1=%0d s2=%0d want 2/10", score1, score2); end
        checks++; if (game_state !== 3'd4 || winner !== 2'b10 || run_en !== 1'b0) begin
            errors++; $display("FAIL win_over: state=%0d winner=%0b run_en=%0b want 4/10/0", game_state, winner, run_en); end
    endtask

    task automatic press_start();
        keycode = 16'h2800;
        tick_clk(1);
        keycode = 16'h0000;
    endtask

    task automatic test_over_gate();
        repeat (30) frame_pulse();
        press_start();
        checks++; if (game_state !== 3'd4) begin errors++; $display("FAIL over_gate30: got %0d want 4", game_state); end
        tick_clk(1);
        repeat (29) frame_pulse();
        press_start();
        checks++; if (game_state !== 3'd4 || score2 !== 8'd10) begin
            errors++; $display("FAIL over_gate59: state=%0d s2=%0d want 4/10", game_state, score2); end
        tick_clk(1);
        frame_pulse();
        press_start();
        checks++; if (game_state !== 3'd1 || score1 !== 8'd0 || score2 !== 8'd0 || winner !== 2'b00) begin
            errors++; $display("FAIL over_gate60: state=%0d s1=%0d s2=%0d w=%0b want 1/0/0/00",
                               game_state, score1, score2, winner); end
        tick_clk(1);
        checks++; if (game_state !== 3'd2 || foodX !== 10'd500 || run_en !== 1'b1) begin
            errors++; $display("FAIL over_restart_play: state=%0d fx=%0d run_en=%0b want 2/500/1", game_state, foodX, run_en); end
    endtask

    task automatic test_death_single();
        OB2Flag = 1'b1;
        frame_pulse();
        OB2Flag = 1'b0;
        checks++; if (game_state !== 3'd4 || winner !== 2'b01 || run_en !== 1'b0) begin
            errors++; $display("FAIL death_ob2: state=%0d winner=%0b run_en=%0b want 4/01/0", game_state, winner, run_en); end
    endtask

    task automatic test_death_both();
        repeat (60) frame_pulse();
        press_start();
        tick_clk(1);
        OB1Flag = 1'b1; OB2Flag = 1'b1;
        frame_pulse();
        OB1Flag = 1'b0; OB2Flag = 1'b0;
        checks++; if (game_state !== 3'd4 || winner !== 2'b11) begin
            errors++; $display("FAIL death_both: state=%0d winner=%0b want 4/11", game_state, winner); end
    endtask

    task automatic test_reset_midplay();
        repeat (60) frame_pulse();
        press_start();
        tick_clk(1);
        snake1X = 10'd504; snake1Y = 10'd404;
        frame_pulse();
        snake1X = 10'd50; snake1Y = 10'd50;
        checks++; if (score1 !== 8'd1) begin errors++; $display("FAIL midplay_eat: s1=%0d want 1", score1); end
        tick_clk(1);
        Reset_n = 1'b0;
        #2;
        checks++; if (game_state !== 3'd0 || run_en !== 1'b0 || score1 !== 8'd0 || food_valid !== 1'b0 || foodX !== 10'd0) begin
            errors++; $display("FAIL midplay_reset: state=%0d run_en=%0b s1=%0d fv=%0b fx=%0d want 0/0/0/0/0",
                               game_state, run_en, score1, food_valid, foodX); end
        frame_pulse();
        checks++; if (game_state !== 3'd0) begin errors++; $display("FAIL reset_hold_tick: got %0d want 0", game_state); end
        Reset_n = 1'b1;
        tick_clk(3);
        checks++; if (game_state !== 3'd0 || run_en !== 1'b0) begin
            errors++; $display("FAIL reset_release: state=%0d run_en=%0b want 0/0", game_state, run_en); end
    endtask

    initial begin
        Reset_n = 1'b1; frame_clk = 1'b0; keycode = 16'h0000;
        randCord = {10'd100, 10'd100};
        snake1X = 10'd300; snake1Y = 10'd300;
        snake2X = 10'd300; snake2Y = 10'd300;
        snake_size = 10'd4;
        OB1Flag = 1'b0; OB2Flag = 1'b0;
        test_reset();
        test_start();
        test_eat_single();
        test_eat_both();
        test_spawn_fallback();
        test_pause();
        test_win();
        test_over_gate();
        test_death_single();
        test_death_both();
        test_reset_midplay();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
